// File: rtl/video_timing_gen.sv
// video_timing_gen
//
// Parametrised raster timing generator. It walks a pixel position (sx, sy)
// over a full frame of H_TOTAL x V_TOTAL positions. For each position it
// produces the sync, data-enable and start-strobe decode. It also keeps a
// wrapping count of completed frames.
//
// Line layout is active, front porch, sync, back porch. Frames use the same
// order, counted in whole lines.
//
// Ports
//   clk_pix      in   pixel clock
//   rst_pix      in   synchronous active-high reset, priority over en
//   en           in   advance enable; low freezes the position
//   sx, sy       out  current pixel position (CORDW bits)
//   hsync        out  horizontal sync, active level H_POL
//   vsync        out  vertical sync, active level V_POL (whole lines)
//   de           out  high inside the active picture
//   line_start   out  one-cycle strobe on entry to sx = 0
//   frame_start  out  one-cycle strobe on entry to (0,0)
//   frame_cnt    out  completed-frame count, wraps at 2**FRAMEW
//
// Every output is a register. Each register is loaded from the same next
// position, so the decode always matches the sx/sy shown in that cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | after reset; outputs at reset values until en is first seen high
// RUN   | raster running; advances on en, freezes (strobes low) without it

module video_timing_gen #(
    parameter int CORDW    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int FRAMEW   = 16
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              en,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              line_start,
    output logic              frame_start,
    output logic [FRAMEW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT_END = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT_END = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_BEG   = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG   = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_n;

    logic [CORDW-1:0]  sx_n, sy_n;
    logic [FRAMEW-1:0] frame_cnt_n;
    logic              hsync_n, vsync_n, de_n;
    logic              line_start_n, frame_start_n;
    logic              load;

    function automatic logic in_window(input logic [CORDW-1:0] v,
                                       input logic [CORDW-1:0] lo,
                                       input logic [CORDW-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state       <= IDLE;
            sx          <= '0;
            sy          <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            sx          <= sx_n;
            sy          <= sy_n;
            hsync       <= hsync_n;
            vsync       <= vsync_n;
            de          <= de_n;
            line_start  <= line_start_n;
            frame_start <= frame_start_n;
            frame_cnt   <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        sx_n          = sx;
        sy_n          = sy;
        frame_cnt_n   = frame_cnt;
        line_start_n  = 1'b0;
        frame_start_n = 1'b0;
        hsync_n       = hsync;
        vsync_n       = vsync;
        de_n          = de;
        load          = 1'b0;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n       = RUN;
                    sx_n          = '0;
                    sy_n          = '0;
                    line_start_n  = 1'b1;
                    frame_start_n = 1'b1;
                    load          = 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    load = 1'b1;
                    if (sx == H_LAST) begin
                        sx_n         = '0;
                        line_start_n = 1'b1;
                        if (sy == V_LAST) begin
                            sy_n          = '0;
                            frame_start_n = 1'b1;
                            frame_cnt_n   = frame_cnt + FRAMEW'(1);
                        end else begin
                            sy_n = sy + CORDW'(1);
                        end
                    end else begin
                        sx_n = sx + CORDW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Decode is taken from the next position so it lands in the same
        // cycle as the sx/sy it describes.
        if (load) begin
            de_n    = (sx_n < H_ACT_END) && (sy_n < V_ACT_END);
            hsync_n = in_window(sx_n, HS_BEG, HS_END) ? HS_ON : ~HS_ON;
            vsync_n = in_window(sy_n, VS_BEG, VS_END) ? VS_ON : ~VS_ON;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, fw;
    } mode_t;

    typedef struct {
        bit run;
        int x, y, fc;
        bit ls, fs;
    } mst_t;

    typedef struct {
        logic [31:0] sx, sy, hs, vs, de, ls, fs, fc;
    } exp_t;

    localparam mode_t MD = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16};
    localparam mode_t MS = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d = 1'b1, en_d = 1'b0;
    logic        rst_s = 1'b1, en_s = 1'b0;
    logic [9:0]  sx_d, sy_d;
    logic        hs_d, vs_d, de_d, ls_d, fs_d;
    logic [15:0] fc_d;
    logic [3:0]  sx_s, sy_s;
    logic        hs_s, vs_s, de_s, ls_s, fs_s;
    logic [1:0]  fc_s;

    video_timing_gen u_dflt (
        .clk_pix(clk), .rst_pix(rst_d), .en(en_d),
        .sx(sx_d), .sy(sy_d), .hsync(hs_d), .vsync(vs_d), .de(de_d),
        .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
    );

    video_timing_gen #(
        .CORDW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .FRAMEW(2)
    ) u_small (
        .clk_pix(clk), .rst_pix(rst_s), .en(en_s),
        .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    mst_t st_d = '{0, 0, 0, 0, 0, 0};
    mst_t st_s = '{0, 0, 0, 0, 0, 0};
    exp_t q_d[$];
    exp_t q_s[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mst_t model_next(mst_t s, mode_t m, bit rst, bit en);
        mst_t n;
        int   ht, vt;
        ht = m.ha + m.hf + m.hs + m.hb;
        vt = m.va + m.vf + m.vs + m.vb;
        n = s;
        n.ls = 0;
        n.fs = 0;
        if (rst) begin
            n.run = 0; n.x = 0; n.y = 0; n.fc = 0;
        end else if (!s.run) begin
            if (en) begin
                n.run = 1; n.x = 0; n.y = 0; n.ls = 1; n.fs = 1;
            end
        end else if (en) begin
            n.x = s.x + 1;
            if (n.x == ht) begin
                n.x  = 0;
                n.ls = 1;
                n.y  = s.y + 1;
                if (n.y == vt) begin
                    n.y  = 0;
                    n.fs = 1;
                    n.fc = (s.fc + 1) % (1 << m.fw);
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(mst_t s, mode_t m);
        exp_t e;
        int   hs0, vs0;
        hs0 = m.ha + m.hf;
        vs0 = m.va + m.vf;
        e.sx = s.x; e.sy = s.y; e.fc = s.fc;
        e.ls = 32'(s.ls); e.fs = 32'(s.fs);
        if (!s.run) begin
            e.de = 0;
            e.hs = (m.hp == 0) ? 1 : 0;
            e.vs = (m.vp == 0) ? 1 : 0;
        end else begin
            e.de = (s.x < m.ha && s.y < m.va) ? 1 : 0;
            if (s.x >= hs0 && s.x < hs0 + m.hs) e.hs = (m.hp != 0) ? 1 : 0;
            else                                e.hs = (m.hp != 0) ? 0 : 1;
            if (s.y >= vs0 && s.y < vs0 + m.vs) e.vs = (m.vp != 0) ? 1 : 0;
            else                                e.vs = (m.vp != 0) ? 0 : 1;
        end
        return e;
    endfunction

    task automatic compare(input string who, input exp_t e, input exp_t o);
        check({who, ".sx"}, o.sx, e.sx);
        check({who, ".sy"}, o.sy, e.sy);
        check({who, ".hsync"}, o.hs, e.hs);
        check({who, ".vsync"}, o.vs, e.vs);
        check({who, ".de"}, o.de, e.de);
        check({who, ".line_start"}, o.ls, e.ls);
        check({who, ".frame_start"}, o.fs, e.fs);
        check({who, ".frame_cnt"}, o.fc, e.fc);
    endtask

    task automatic tick();
        exp_t od, os;
        st_d = model_next(st_d, MD, rst_d, en_d);
        q_d.push_back(expect_of(st_d, MD));
        st_s = model_next(st_s, MS, rst_s, en_s);
        q_s.push_back(expect_of(st_s, MS));
        @(posedge clk);
        #1;
        od = '{32'(sx_d), 32'(sy_d), 32'(hs_d), 32'(vs_d), 32'(de_d),
               32'(ls_d), 32'(fs_d), 32'(fc_d)};
        os = '{32'(sx_s), 32'(sy_s), 32'(hs_s), 32'(vs_s), 32'(de_s),
               32'(ls_s), 32'(fs_s), 32'(fc_s)};
        compare("dflt", q_d.pop_front(), od);
        compare("small", q_s.pop_front(), os);
    endtask

    initial begin
        int ls_cnt, de_cnt, hs_cnt, hs_first, hs_last, cyc, last_fs, pulses;
        int vs_hi, hs_hi;
        bit reached;

        // reset, then idle with en low
        repeat (3) tick();
        check("rst.de", 32'(de_d), 0);
        check("rst.hsync", 32'(hs_d), 1);
        rst_d = 0; rst_s = 0;
        repeat (2) tick();
        check("idle.de", 32'(de_d), 0);
        check("idle.frame_start", 32'(fs_d), 0);

        // first cycle out of IDLE
        en_d = 1;
        tick();
        check("first.sx", 32'(sx_d), 0);
        check("first.de", 32'(de_d), 1);
        check("first.line_start", 32'(ls_d), 1);
        check("first.frame_start", 32'(fs_d), 1);
        check("first.hv", {30'd0, hs_d, vs_d}, 3);
        check("first.frame_cnt", 32'(fc_d), 0);
        ls_cnt = 1;
        tick();
        check("second.sx", 32'(sx_d), 1);
        check("second.strobes", {30'd0, ls_d, fs_d}, 0);

        // run to (100,3), measuring line 1
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; reached = 0;
        for (int i = 0; i < 5000 && !reached; i++) begin
            tick();
            ls_cnt += int'(ls_d);
            if (sy_d == 1) begin
                de_cnt += int'(de_d);
                if (!hs_d) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(sx_d);
                    hs_last = int'(sx_d);
                end
            end
            reached = (sx_d == 100 && sy_d == 3);
        end
        check("reach_100_3", 32'(reached), 1);
        check("line1.de_count", de_cnt, 640);
        check("line1.hsync_low_count", hs_cnt, 96);
        check("line1.hsync_first", hs_first, 656);
        check("line1.hsync_last", hs_last, 751);
        check("line_start_count", ls_cnt, 4);

        // pause at (100,3)
        en_d = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause.pos", {12'd0, sy_d, sx_d}, {12'd0, 10'd3, 10'd100});
            check("pause.de", 32'(de_d), 1);
        end
        en_d = 1;
        tick();
        check("resume.sx", 32'(sx_d), 101);

        // pause exactly at sx=0: no second line_start on resume
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            tick();
            reached = (sx_d == 0);
        end
        check("reach_sx0", 32'(reached), 1);
        check("sx0.line_start", 32'(ls_d), 1);
        en_d = 0;
        repeat (3) tick();
        check("sx0_pause.line_start", 32'(ls_d), 0);
        en_d = 1;
        tick();
        check("sx0_resume.line_start", 32'(ls_d), 0);
        check("sx0_resume.sx", 32'(sx_d), 1);

        // reset mid-line
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            tick();
            reached = (sx_d == 300);
        end
        check("reach_sx300", 32'(reached), 1);
        rst_d = 1;
        tick();
        check("midrst.de", 32'(de_d), 0);
        check("midrst.frame_cnt", 32'(fc_d), 0);
        check("midrst.sx", 32'(sx_d), 0);
        rst_d = 0;
        tick();
        check("restart.frame_start", 32'(fs_d), 1);
        check("restart.de", 32'(de_d), 1);
        en_d = 0;

        // small mode: period, sync counts, frame_cnt wrap
        en_s = 1;
        cyc = 0; last_fs = -1; pulses = 0; vs_hi = 0; hs_hi = 0;
        for (int i = 0; i < 700 && pulses < 5; i++) begin
            tick();
            cyc++;
            if (fs_s) begin
                check("small.fc_at_start", 32'(fc_s), pulses % 4);
                if (last_fs >= 0) check("small.period", cyc - last_fs, 98);
                if (pulses == 1) begin
                    check("small.vsync_hi", vs_hi, 14);
                    check("small.hsync_hi", hs_hi, 14);
                end
                last_fs = cyc;
                pulses++;
            end
            if (pulses == 1) begin
                vs_hi += int'(vs_s);
                hs_hi += int'(hs_s);
            end
        end
        check("small.frame_pulses", pulses, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 480p signal generator.
- Produces pixel coordinates, hsync/vsync, data enable, line and frame start strobes, and a frame counter for any CEA/VESA-style mode. Timing values and sync polarities are set by parameters.
- Sits between the pixel clock source and the drawing logic / rgb2dvi path.
- Adds three things the fixed generator lacks: pause (en), start strobes, and a frame count.

Parameters:
- CORDW, 10, width of sx/sy; must satisfy 2**CORDW >= max(H_TOTAL, V_TOTAL).
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level.
- FRAMEW, 16, width of frame_cnt.

Ports:
- clk_pix  input  1  pixel clock.
- rst_pix  input  1  synchronous, active-high reset.
- en  input  1  advance enable; when low, position is frozen.
- sx  output  CORDW  horizontal position.
- sy  output  CORDW  vertical position.
- hsync  output  1  horizontal sync, polarity H_POL.
- vsync  output  1  vertical sync, polarity V_POL.
- de  output  1  high when sx < H_ACTIVE and sy < V_ACTIVE.
- line_start  output  1  one-cycle strobe when sx becomes 0.
- frame_start  output  1  one-cycle strobe when (sx,sy) becomes (0,0).
- frame_cnt  output  FRAMEW  completed-frame count, wrapping.

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 800).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 525).
- Line order is active, front porch, sync, back porch; frames use the same order.
- All outputs are registered and mutually aligned: in any cycle, hsync/vsync/de/strobes are the decode of the sx/sy shown in that same cycle.
- Sync decode:
  - hsync = H_POL when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vsync uses the same rule on sy with V_ACTIVE, V_FP, V_SYNC, V_POL, and applies for whole lines.
- State machine, two states (IDLE, RUN):
  - Reset (rst_pix high at an edge) forces IDLE with outputs: sx=0, sy=0, de=0, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0, frame_cnt=0.
  - IDLE with en=0: hold the reset outputs.
  - IDLE with en=1: go to RUN and load position (0,0) with its decode, so de=1, line_start=1, frame_start=1.
  - RUN with en=1: advance sx by 1.
    - At sx=H_TOTAL-1, sx wraps to 0 and sy increments.
    - At sx=H_TOTAL-1 and sy=V_TOTAL-1, both wrap to 0 and frame_cnt increments (modulo 2**FRAMEW).
  - RUN with en=0: sx, sy, hsync, vsync, de and frame_cnt hold; line_start and frame_start are forced to 0.
  - On resume, a position re-entered after a pause does not re-strobe; strobes fire only on a transition into sx=0 or (0,0).
- frame_cnt:
  - Increments on the same edge that frame_start rises for frame N+1.
  - The first frame after reset reports frame_cnt=0.
- rst_pix has priority over en and takes effect mid-line or mid-frame; no partial-frame recovery.
- Width rule: counter comparisons use CORDW-bit unsigned values; no counter ever exceeds its TOTAL-1.
- Latency: 1 cycle from an enabled edge to the updated outputs.

Test Plan:
- Reset, then en=1 held, defaults:
  - First cycle out of IDLE: sx=0, sy=0, de=1, line_start=1, frame_start=1, hsync=vsync=1, frame_cnt=0.
  - Next cycle: sx=1, both strobes 0.
- Default line decode:
  - de=1 for sx 0..639 and 0 for 640..799.
  - hsync=0 exactly for sx 656..751.
  - line_start pulses every 800 cycles with sy incrementing.
- Full frame, defaults:
  - vsync=0 for sy 490..491 across all 800 pixels of those lines.
  - After 420000 enabled cycles, frame_start=1 again, frame_cnt=1, sx=sy=0.
- Pause:
  - Drop en for 5 cycles at sx=100, sy=3: sx/sy/de hold at 100/3/1.
  - Re-raise en: next cycle sx=101.
  - Pausing at sx=0 gives no second line_start on resume.
- Reset mid-frame at sy=200, sx=300:
  - Next cycle shows reset outputs (de=0, frame_cnt=0).
  - The restart from IDLE strobes frame_start.
- Small mode H=8,2,2,2; V=4,1,1,1; H_POL=V_POL=1; FRAMEW=2:
  - hsync=1 for sx 10..11.
  - vsync=1 on sy=5.
  - frame period is 98 cycles.
  - frame_cnt wraps 3->0 at the 4th frame boundary.
